ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xF4 enable reporting, 0xFF reset) from the FPGA to the mouse over the shared `ps2_clk`/`ps2_data` open-drain lines. It performs the inhibit / request-to-send sequence, shifts data on device-generated clock edges, checks the device ACK and enforces a timeout. It sits in the input section next to the mouse receiver. The top level combines its pull-low enables with the receiver's, and this block drives the lines only while `busy`=1.

---
 rtl/ps2_host_tx.sv | 192 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit/request-to-send, shifts one byte on
// device clock edges, checks the device ACK and aborts on a frame timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6500,
    parameter int RTS_CYCLES     = 65,
    parameter int TIMEOUT_CYCLES = 1_300_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int MAX_A = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int MAX_C = (MAX_A > RTS_CYCLES) ? MAX_A : RTS_CYCLES;
    localparam int CNT_W = $clog2(MAX_C) + 1;
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t           r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [3:0]       r_bit, w_bit_n, w_bit_inc;
    logic             r_err, w_err_n;
    logic             w_clk_oe_n, w_data_oe_n, w_busy_n;
    logic             w_done_n, w_ack_err_n, w_timeout_n;
    logic             w_accept;
    logic [10:0]      r_frame;
    logic [1:0]       r_clk_sync, r_dat_sync;
    logic             r_clk_d, r_fall;

    // Line synchronizers reset to the idle (released) level so reset exit
    // never manufactures a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_d    <= 1'b1;
            r_fall     <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk_i};
            r_dat_sync <= {r_dat_sync[0], ps2_data_i};
            r_clk_d    <= r_clk_sync[1];
            r_fall     <= r_clk_d & ~r_clk_sync[1];
        end
    end

    // Frame as sent, bit 0 first: start, data LSB first, odd parity, stop.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_frame <= {1'b1, ~^tx_data, tx_data, 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_err       <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_bit       <= w_bit_n;
            r_err       <= w_err_n;
            ps2_clk_oe  <= w_clk_oe_n;
            ps2_data_oe <= w_data_oe_n;
            busy        <= w_busy_n;
            done        <= w_done_n;
            ack_err     <= w_ack_err_n;
            timeout     <= w_timeout_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_bit_n     = r_bit;
        w_err_n     = r_err;
        w_clk_oe_n  = ps2_clk_oe;
        w_data_oe_n = ps2_data_oe;
        w_busy_n    = busy;
        w_done_n    = 1'b0;
        w_ack_err_n = 1'b0;
        w_timeout_n = 1'b0;
        w_accept    = 1'b0;
        w_bit_inc   = r_bit + 4'd1;

        case (r_state)
            S_IDLE: begin
                w_cnt_n     = '0;
                w_bit_n     = '0;
                w_err_n     = 1'b0;
                w_clk_oe_n  = 1'b0;
                w_data_oe_n = 1'b0;
                w_busy_n    = 1'b0;
                if (tx_start) begin
                    w_accept   = 1'b1;
                    w_state_n  = S_INHIBIT;
                    w_busy_n   = 1'b1;
                    w_clk_oe_n = 1'b1;
                end
            end
            S_INHIBIT: begin
                if (r_cnt == INH_LAST) begin
                    w_state_n   = S_RTS;
                    w_cnt_n     = '0;
                    w_data_oe_n = 1'b1;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            S_RTS: begin
                // Releasing the clock hands timing to the device; the same
                // counter now measures the frame timeout.
                if (r_cnt == RTS_LAST) begin
                    w_state_n  = S_SHIFT;
                    w_cnt_n    = '0;
                    w_bit_n    = '0;
                    w_clk_oe_n = 1'b0;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                w_cnt_n = r_cnt + CNT_W'(1);
                if (r_fall) begin
                    w_bit_n     = w_bit_inc;
                    w_data_oe_n = ~r_frame[w_bit_inc];
                    if (w_bit_inc == 4'd10) begin
                        w_state_n = S_ACK;
                    end
                end
            end
            S_ACK: begin
                w_cnt_n = r_cnt + CNT_W'(1);
                if (r_fall) begin
                    w_err_n   = r_dat_sync[1];
                    w_state_n = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                w_cnt_n = r_cnt + CNT_W'(1);
                if (r_clk_sync[1] && r_dat_sync[1]) begin
                    w_done_n    = 1'b1;
                    w_ack_err_n = r_err;
                    w_busy_n    = 1'b0;
                    w_state_n   = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        // Timeout overrides any device-phase progress in the same cycle.
        if ((r_state == S_SHIFT || r_state == S_ACK || r_state == S_WAIT_IDLE) &&
            r_cnt == TO_LAST) begin
            w_state_n   = S_IDLE;
            w_clk_oe_n  = 1'b0;
            w_data_oe_n = 1'b0;
            w_busy_n    = 1'b0;
            w_done_n    = 1'b0;
            w_ack_err_n = 1'b0;
            w_timeout_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device drives the open-drain lines
// and the sent frames are compared with the frame expected for each byte.
module tb_ps2_host_tx;

    localparam int INH = 200;
    localparam int RTS = 10;
    localparam int TO  = 1000;
    localparam int HP  = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       busy, done, ack_err, timeout;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk_i, ps2_data_i;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0, done_tot = 0, ackerr_tot = 0, lone_err_tot = 0, to_tot = 0;
    int t_to = 0, t_rel = 0, t_clk_up = 0, t_dat_up = 0, run = 0, last_run = 0;
    logic to_oe = 1'b0, prev_clk_oe = 1'b0, prev_dat_oe = 1'b0;

    assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_i = ~(ps2_data_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .RTS_CYCLES    (RTS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .timeout    (timeout),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Running event totals; tests take before/after differences.
    always @(negedge clk) begin
        cyc++;
        if (done) done_tot++;
        if (ack_err) ackerr_tot++;
        if (ack_err && !done) lone_err_tot++;
        if (timeout) begin
            to_tot++;
            t_to  = cyc;
            to_oe = ps2_clk_oe | ps2_data_oe;
        end
        if (prev_clk_oe && !ps2_clk_oe) t_rel = cyc;
        if (!prev_clk_oe && ps2_clk_oe) t_clk_up = cyc;
        if (!prev_dat_oe && ps2_data_oe) t_dat_up = cyc;
        if (ps2_clk_oe) run++;
        else begin
            if (run != 0) last_run = run;
            run = 0;
        end
        prev_clk_oe = ps2_clk_oe;
        prev_dat_oe = ps2_data_oe;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Expected data_oe per frame position: oe = ~bit, parity makes ones odd.
    function automatic logic [10:0] expected_oe(input logic [7:0] d);
        logic [10:0] e;
        int ones;
        bit par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        par  = ((ones % 2) == 0);
        e[0] = 1'b1;
        for (int i = 0; i < 8; i++) e[i+1] = !d[i];
        e[9]  = !par;
        e[10] = 1'b0;
        return e;
    endfunction

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        chk("busy_after_start", busy, 1);
        chk("clk_oe_after_start", ps2_clk_oe, 1);
    endtask

    task automatic dev_send(input logic [7:0] d, input bit noack, input bit inject, input int rst_edge);
        logic [10:0] oe_seen;
        int d0, a0, l0;
        bit ok;
        oe_seen = '0;
        d0 = done_tot;
        a0 = ackerr_tot;
        l0 = lone_err_tot;
        start_tx(d);
        ok = 0;
        for (int w = 0; w < 1000; w++) begin
            @(negedge clk);
            if (ps2_clk_i && !ps2_data_i) begin
                ok = 1;
                break;
            end
        end
        chk("rts_seen", ok, 1);
        if (!ok) return;
        chk("data_oe_after_inhibit", t_dat_up - t_clk_up, INH);
        for (int e = 1; e <= 11; e++) begin
            if (e == 11) dev_dat_low = !noack;
            repeat (HP) @(negedge clk);
            if (e == 1) oe_seen[0] = ps2_data_oe;
            dev_clk_low = 1'b1;
            for (int c = 0; c < HP; c++) begin
                @(negedge clk);
                if (inject && e == 3 && c == 8) begin
                    tx_data  = 8'h55;
                    tx_start = 1'b1;
                end else begin
                    tx_start = 1'b0;
                end
                if (rst_edge == e && c == 10) begin
                    #1 rst = 1'b0;
                    #1;
                    chk("rst_clk_oe", ps2_clk_oe, 0);
                    chk("rst_data_oe", ps2_data_oe, 0);
                    chk("rst_busy", busy, 0);
                    @(negedge clk);
                    rst = 1'b1;
                    dev_clk_low = 1'b0;
                    dev_dat_low = 1'b0;
                    repeat (10) @(negedge clk);
                    return;
                end
            end
            if (e <= 10) oe_seen[e] = ps2_data_oe;
            dev_clk_low = 1'b0;
        end
        repeat (HP) @(negedge clk);
        dev_dat_low = 1'b0;
        ok = 0;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (done_tot != d0) begin
                ok = 1;
                break;
            end
        end
        chk("done_seen", ok, 1);
        repeat (5) @(negedge clk);
        chk("oe_pattern", oe_seen, expected_oe(d));
        chk("done_count", done_tot - d0, 1);
        chk("ack_err_count", ackerr_tot - a0, noack);
        chk("ack_err_without_done", lone_err_tot - l0, 0);
        chk("clk_oe_length", last_run, INH + RTS);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic timeout_test();
        int t0, d0;
        bit ok;
        t0 = to_tot;
        d0 = done_tot;
        start_tx(8'hA5);
        ok = 0;
        for (int w = 0; w < INH + RTS + TO + 200; w++) begin
            @(negedge clk);
            if (to_tot != t0) begin
                ok = 1;
                break;
            end
        end
        chk("timeout_seen", ok, 1);
        chk("timeout_delay", t_to - t_rel, TO);
        chk("timeout_lines_released", to_oe, 0);
        repeat (5) @(negedge clk);
        chk("timeout_count", to_tot - t0, 1);
        chk("timeout_no_done", done_tot - d0, 0);
        chk("timeout_busy", busy, 0);
    endtask

    initial begin
        logic [7:0] rb;
        bit         rn;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {busy, done, ack_err, timeout, ps2_clk_oe, ps2_data_oe}, 0);

        dev_send(8'hF4, 1'b0, 1'b0, 0);
        dev_send(8'hFF, 1'b0, 1'b0, 0);
        dev_send(8'h00, 1'b1, 1'b0, 0);
        dev_send(8'hF4, 1'b0, 1'b1, 0);
        timeout_test();
        dev_send(8'hF4, 1'b0, 1'b0, 5);
        chk("post_reset_idle", {busy, ps2_clk_oe, ps2_data_oe}, 0);
        dev_send(8'hF4, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            rn = 1'($urandom_range(0, 1));
            dev_send(rb, rn, 1'b0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
